// File: rtl/inst_fetch_pkg.sv
// Shared types and defaults for the instruction fetch unit.
package inst_fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int unsigned DEPTH_DEFAULT    = 2;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  // Circular pointer increment for queues of up to 8 entries.
  function automatic logic [2:0] ptr_inc(input logic [2:0] ptr, input int unsigned depth);
    return (ptr == 3'(depth - 1)) ? 3'd0 : ptr + 3'd1;
  endfunction

endpackage

// File: rtl/inst_fetch_fifo.sv
// DEPTH-entry instruction buffer of {pc, inst}; flush has priority over push and pop.
module fetch_fifo
  import inst_fetch_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEFAULT,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  fetch_entry_t     push_data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output fetch_entry_t     head_o,
  output logic [CNT_W-1:0] count_o,
  output logic             empty_o,
  output logic             full_o
);

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_push  = push_i && !flush_i;
    do_pop   = pop_i && !flush_i && (count_q != '0);
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = PTR_W'(ptr_inc(3'(wr_ptr_q), DEPTH));
      if (do_pop)  rd_ptr_d = PTR_W'(ptr_inc(3'(rd_ptr_q), DEPTH));
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is pure datapath; the head is only observed when count is non-zero.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: credit-based request issue, in-order PC queue, redirect flush with stale-response discard.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned DEPTH    = DEPTH_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o,
  output logic [31:0] inst_pc4_o,
  input  logic        inst_ready_i,
  output logic        err_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned SUM_W = CNT_W + 1;

  fetch_state_t     state_q, state_d;
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic             pending_q, pending_d;
  logic [CNT_W-1:0] outstanding_q, outstanding_d;
  logic [CNT_W-1:0] discard_q, discard_d;
  logic             err_q, err_d;
  logic [31:0]      pcq_q [DEPTH];
  logic [PTR_W-1:0] pcq_wr_q, pcq_wr_d;
  logic [PTR_W-1:0] pcq_rd_q, pcq_rd_d;

  logic             req_pre;
  logic             gnt_acc;
  logic             rsp_ok;
  logic             fifo_push;
  logic             fifo_pop;
  logic [SUM_W-1:0] credit_used;
  fetch_entry_t     fifo_wdata;
  fetch_entry_t     fifo_head;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_empty;
  logic             fifo_full;

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    pending_d     = 1'b0;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;
    err_d         = err_q;
    pcq_wr_d      = pcq_wr_q;
    pcq_rd_d      = pcq_rd_q;
    req_pre       = 1'b0;
    mem_req_o     = 1'b0;

    fifo_pop = !fifo_empty && inst_ready_i && !redirect_i;
    // A slot popped this cycle counts as free, which sustains one fetch per cycle.
    credit_used = SUM_W'(outstanding_q) + SUM_W'(fifo_count) - SUM_W'(fifo_pop);

    case (state_q)
      BOOT:    state_d = RUN;
      RUN:     req_pre = pending_q || (credit_used < SUM_W'(DEPTH));
      default: state_d = BOOT;
    endcase

    // A grant is honoured against the request as presented before the redirect mask.
    mem_req_o  = req_pre && !redirect_i;
    gnt_acc    = req_pre && mem_gnt_i;
    rsp_ok     = mem_rvalid_i && (outstanding_q != '0);
    fifo_push  = rsp_ok && (discard_q == '0);
    fifo_wdata = '{pc: pcq_q[pcq_rd_q], inst: mem_rdata_i};
    pending_d  = mem_req_o && !mem_gnt_i;

    if (gnt_acc) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
      pcq_wr_d   = PTR_W'(ptr_inc(3'(pcq_wr_q), DEPTH));
    end
    if (rsp_ok) begin
      pcq_rd_d = PTR_W'(ptr_inc(3'(pcq_rd_q), DEPTH));
      if (discard_q != '0) discard_d = discard_q - CNT_W'(1);
    end
    case ({gnt_acc, rsp_ok})
      2'b10:   outstanding_d = outstanding_q + CNT_W'(1);
      2'b01:   outstanding_d = outstanding_q - CNT_W'(1);
      default: outstanding_d = outstanding_q;
    endcase
    if (mem_rvalid_i && (outstanding_q == '0)) err_d = 1'b1;

    // Every response still in flight after this cycle is stale once we redirect.
    if (redirect_i) begin
      fetch_pc_d = redirect_pc_i & ~32'h3;
      discard_d  = outstanding_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= BOOT;
      fetch_pc_q    <= {RESET_PC[31:2], 2'b00};
      pending_q     <= 1'b0;
      outstanding_q <= '0;
      discard_q     <= '0;
      err_q         <= 1'b0;
      pcq_wr_q      <= '0;
      pcq_rd_q      <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      pending_q     <= pending_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      err_q         <= err_d;
      pcq_wr_q      <= pcq_wr_d;
      pcq_rd_q      <= pcq_rd_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (gnt_acc) pcq_q[pcq_wr_q] <= fetch_pc_q;
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (fifo_push),
    .push_data_i (fifo_wdata),
    .pop_i       (fifo_pop),
    .flush_i     (redirect_i),
    .head_o      (fifo_head),
    .count_o     (fifo_count),
    .empty_o     (fifo_empty),
    .full_o      (fifo_full)
  );

  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(fifo_push && !redirect_i && fifo_full && !fifo_pop));

  assign mem_addr_o   = fetch_pc_q;
  assign inst_valid_o = !fifo_empty;
  assign inst_o       = fifo_empty ? 32'h0 : fifo_head.inst;
  assign inst_pc_o    = fifo_empty ? 32'h0 : fifo_head.pc;
  assign inst_pc4_o   = inst_pc_o + 32'd4;
  assign err_o        = err_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch with a fixed-latency in-order memory model.
module tb_inst_fetch;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic [31:0] inst_pc4_o;
  logic        inst_ready_i;
  logic        err_o;

  inst_fetch #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .mem_req_o     (mem_req_o),
    .mem_addr_o    (mem_addr_o),
    .mem_gnt_i     (mem_gnt_i),
    .mem_rvalid_i  (mem_rvalid_i),
    .mem_rdata_i   (mem_rdata_i),
    .inst_valid_o  (inst_valid_o),
    .inst_o        (inst_o),
    .inst_pc_o     (inst_pc_o),
    .inst_pc4_o    (inst_pc4_o),
    .inst_ready_i  (inst_ready_i),
    .err_o         (err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int          due;
    logic [31:0] addr;
  } rsp_t;

  typedef struct {
    bit          start;
    bit          rdy;
    bit          redir;
    logic [31:0] rpc;
    bit          e_req;
    logic [31:0] e_addr;
    bit          e_valid;
    logic [31:0] e_pc;
  } vec_t;

  rsp_t resp_q[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   cyc_n = 0;
  int   n_gnt = 0;
  int   lat   = 1;
  bit   gnt_en = 1'b1;
  bit   spur   = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_5A5A;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  // Memory decides its grant on the request it sees, then the redirect is applied.
  task automatic begin_cycle(input bit rdy, input bit redir, input logic [31:0] rpc);
    inst_ready_i  = rdy;
    redirect_i    = 1'b0;
    redirect_pc_i = rpc;
    mem_rvalid_i  = 1'b0;
    mem_rdata_i   = 32'h0;
    if (spur) begin
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = 32'h1234_5678;
    end else if (resp_q.size() > 0 && resp_q[0].due == cyc_n) begin
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = mem_word(resp_q[0].addr);
      void'(resp_q.pop_front());
    end
    #1;
    mem_gnt_i  = gnt_en && mem_req_o;
    redirect_i = redir;
    #1;
  endtask

  task automatic end_cycle();
    if (mem_gnt_i) begin
      n_gnt++;
      resp_q.push_back('{due: cyc_n + lat, addr: mem_addr_o});
    end
    @(posedge clk_i);
    #1;
    cyc_n++;
  endtask

  task automatic do_reset();
    rst_i         = 1'b1;
    redirect_i    = 1'b0;
    redirect_pc_i = 32'h0;
    mem_gnt_i     = 1'b0;
    mem_rvalid_i  = 1'b0;
    mem_rdata_i   = 32'h0;
    inst_ready_i  = 1'b0;
    spur          = 1'b0;
    resp_q.delete();
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_req", mem_req_o, 0);
    chk("rst_addr", mem_addr_o, 32'h0);
    chk("rst_valid", inst_valid_o, 0);
    chk("rst_inst", inst_o, 32'h0);
    chk("rst_pc", inst_pc_o, 32'h0);
    chk("rst_pc4", inst_pc4_o, 32'h4);
    chk("rst_err", err_o, 0);
    rst_i = 1'b0;
    cyc_n = 0;
    n_gnt = 0;
  endtask

  task automatic wait_valid(input int budget, output bit found);
    found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      begin_cycle(1'b1, 1'b0, 32'h0);
      if (inst_valid_o) begin
        found = 1'b1;
        break;
      end
      end_cycle();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt [14];
    bit   found;

    // Back-to-back stream, then a redirect to the top of the address space.
    vt[0]  = '{1, 1, 0, 32'h0,         0, 32'h0,         0, 32'h0};
    vt[1]  = '{0, 1, 0, 32'h0,         1, 32'h0,         0, 32'h0};
    vt[2]  = '{0, 1, 0, 32'h0,         1, 32'h4,         0, 32'h0};
    vt[3]  = '{0, 1, 0, 32'h0,         1, 32'h8,         1, 32'h0};
    vt[4]  = '{0, 1, 0, 32'h0,         1, 32'hC,         1, 32'h4};
    vt[5]  = '{0, 1, 0, 32'h0,         1, 32'h10,        1, 32'h8};
    vt[6]  = '{0, 1, 0, 32'h0,         1, 32'h14,        1, 32'hC};
    vt[7]  = '{0, 1, 0, 32'h0,         1, 32'h18,        1, 32'h10};
    vt[8]  = '{1, 1, 0, 32'h0,         0, 32'h0,         0, 32'h0};
    vt[9]  = '{0, 1, 1, 32'hFFFF_FFFE, 0, 32'h0,         0, 32'h0};
    vt[10] = '{0, 1, 0, 32'h0,         1, 32'hFFFF_FFFC, 0, 32'h0};
    vt[11] = '{0, 1, 0, 32'h0,         1, 32'h0,         0, 32'h0};
    vt[12] = '{0, 1, 0, 32'h0,         1, 32'h4,         1, 32'hFFFF_FFFC};
    vt[13] = '{0, 1, 0, 32'h0,         1, 32'h8,         1, 32'h0};

    lat    = 1;
    gnt_en = 1'b1;
    for (int i = 0; i < 14; i++) begin
      if (vt[i].start) do_reset();
      begin_cycle(vt[i].rdy, vt[i].redir, vt[i].rpc);
      chk($sformatf("row%0d_req", i), mem_req_o, vt[i].e_req);
      chk($sformatf("row%0d_addr", i), mem_addr_o, vt[i].e_addr);
      chk($sformatf("row%0d_valid", i), inst_valid_o, vt[i].e_valid);
      chk($sformatf("row%0d_pc", i), inst_pc_o, vt[i].e_pc);
      chk($sformatf("row%0d_pc4", i), inst_pc4_o, vt[i].e_pc + 32'd4);
      if (vt[i].e_valid) chk($sformatf("row%0d_inst", i), inst_o, mem_word(vt[i].e_pc));
      end_cycle();
    end
    chk("stream_err", err_o, 0);

    // Decode stalled: credits cap in-flight plus buffered at DEPTH.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      begin_cycle(1'b0, 1'b0, 32'h0);
      if (i == 9) begin
        chk("stall_req_low", mem_req_o, 0);
        chk("stall_grants", 32'(n_gnt), 32'd2);
        chk("stall_head_pc", inst_pc_o, 32'h0);
      end
      end_cycle();
    end
    for (int i = 0; i < 4; i++) begin
      begin_cycle(1'b1, 1'b0, 32'h0);
      chk($sformatf("release%0d_valid", i), inst_valid_o, 1);
      chk($sformatf("release%0d_pc", i), inst_pc_o, 32'(4 * i));
      end_cycle();
    end

    // Redirect with two requests in flight and slow memory.
    do_reset();
    lat = 3;
    for (int i = 0; i < 3; i++) begin
      begin_cycle(1'b1, 1'b0, 32'h0);
      end_cycle();
    end
    chk("flush_inflight", 32'(n_gnt), 32'd2);
    begin_cycle(1'b1, 1'b1, 32'h103);
    chk("flush_req_low", mem_req_o, 0);
    end_cycle();
    wait_valid(30, found);
    chk("flush_found", found, 1);
    if (found) begin
      chk("flush_first_pc", inst_pc_o, 32'h100);
      chk("flush_first_inst", inst_o, mem_word(32'h100));
      end_cycle();
    end
    wait_valid(30, found);
    chk("flush_second_found", found, 1);
    if (found) begin
      chk("flush_second_pc", inst_pc_o, 32'h104);
      end_cycle();
    end

    // Redirect coinciding with a grant: both older responses must be discarded.
    do_reset();
    lat = 3;
    for (int i = 0; i < 2; i++) begin
      begin_cycle(1'b1, 1'b0, 32'h0);
      end_cycle();
    end
    begin_cycle(1'b1, 1'b1, 32'h200);
    chk("gntflush_req_low", mem_req_o, 0);
    chk("gntflush_grants", 32'(n_gnt + 32'(mem_gnt_i)), 32'd2);
    end_cycle();
    wait_valid(30, found);
    chk("gntflush_found", found, 1);
    if (found) begin
      chk("gntflush_first_pc", inst_pc_o, 32'h200);
      end_cycle();
    end

    // Spurious response with nothing outstanding.
    do_reset();
    lat    = 1;
    gnt_en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      begin_cycle(1'b1, 1'b0, 32'h0);
      end_cycle();
    end
    spur = 1'b1;
    begin_cycle(1'b1, 1'b0, 32'h0);
    end_cycle();
    spur = 1'b0;
    begin_cycle(1'b1, 1'b0, 32'h0);
    chk("spur_err", err_o, 1);
    chk("spur_valid", inst_valid_o, 0);
    end_cycle();
    for (int i = 0; i < 5; i++) begin
      begin_cycle(1'b1, 1'b0, 32'h0);
      end_cycle();
    end
    begin_cycle(1'b1, 1'b0, 32'h0);
    chk("spur_err_sticky", err_o, 1);
    chk("spur_valid_late", inst_valid_o, 0);
    end_cycle();
    gnt_en = 1'b1;
    do_reset();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
